// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: synchronise, deglitch and deframe 11-bit frames.
// Optional parity checking is enabled with the PS2_PARITY_CHECK_EN macro.
module ps2_rx_frame #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_PS2C,
    input  logic        i_PS2D,
    output logic [23:0] o_Data,
    output logic [7:0]  o_Byte,
    output logic        o_Valid,
    output logic        o_Error,
    output logic        o_Busy
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0]    FL_MAX = 8'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          c_meta, c_sync, d_meta, d_sync;
    logic          filt;
    logic [7:0]    filt_cnt;
    logic          fall;
    logic [TW-1:0] to_cnt;
    logic          timeout;

    state_t        state, state_nx;
    logic [7:0]    shift, shift_nx;
    logic [2:0]    bit_cnt, bit_cnt_nx;
    logic [7:0]    byte_nx;
    logic [23:0]   data_nx;
    logic          valid_nx, error_nx;
    logic          good;
`ifdef PS2_PARITY_CHECK_EN
    logic          par, par_nx;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            c_meta   <= 1'b1;
            c_sync   <= 1'b1;
            d_meta   <= 1'b1;
            d_sync   <= 1'b1;
            filt     <= 1'b1;
            filt_cnt <= '0;
        end else begin
            c_meta <= i_PS2C;
            c_sync <= c_meta;
            d_meta <= i_PS2D;
            d_sync <= d_meta;
            if (c_sync != filt) begin
                if (filt_cnt == FL_MAX) begin
                    filt     <= c_sync;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 8'd1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // The fall event is the cycle in which the filtered clock commits to 0.
    assign fall    = filt && !c_sync && (filt_cnt == FL_MAX);
    assign timeout = (state != IDLE) && (to_cnt == TO_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            to_cnt <= '0;
        end else if (state == IDLE || fall || timeout) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            o_Byte  <= '0;
            o_Data  <= '0;
            o_Valid <= 1'b0;
            o_Error <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            shift   <= shift_nx;
            bit_cnt <= bit_cnt_nx;
            o_Byte  <= byte_nx;
            o_Data  <= data_nx;
            o_Valid <= valid_nx;
            o_Error <= error_nx;
`ifdef PS2_PARITY_CHECK_EN
            par     <= par_nx;
`endif
        end
    end

    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    always_comb begin
        state_nx   = state;
        shift_nx   = shift;
        bit_cnt_nx = bit_cnt;
        byte_nx    = o_Byte;
        data_nx    = o_Data;
        valid_nx   = 1'b0;
        error_nx   = 1'b0;
        good       = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_nx     = par;
`endif
        if (fall) begin
            unique case (state)
                IDLE: begin
                    if (!d_sync) begin
                        state_nx   = DATA;
                        bit_cnt_nx = '0;
                    end else begin
                        error_nx = 1'b1;
                    end
                end
                DATA: begin
                    shift_nx   = {d_sync, shift[7:1]};
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nx = PARITY;
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_nx = d_sync;
`endif
                    state_nx = STOP;
                end
                STOP: begin
`ifdef PS2_PARITY_CHECK_EN
                    good = d_sync && ((^shift) ^ par);
`else
                    good = d_sync;
`endif
                    if (good) begin
                        byte_nx  = shift;
                        data_nx  = {o_Data[15:0], shift};
                        valid_nx = 1'b1;
                    end else begin
                        error_nx = 1'b1;
                    end
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end else if (timeout) begin
            state_nx = IDLE;
            error_nx = 1'b1;
        end
    end

    assign o_Busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: directed scenarios plus random frames
// checked against a frame-level reference model.
module tb_ps2_rx_frame;

    localparam int FL   = 8;
    localparam int TO   = 2000;
    localparam int HALF = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2c = 1'b1;
    logic        ps2d = 1'b1;
    logic [23:0] o_data;
    logic [7:0]  o_byte;
    logic        o_valid, o_error, o_busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        err;
        logic [7:0]  b;
        logic [23:0] d;
    } exp_t;
    exp_t sb[$];

    logic [23:0] m_hist = '0;
    logic [7:0]  m_last = '0;

    ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_PS2C(ps2c), .i_PS2D(ps2d),
        .o_Data(o_data), .o_Byte(o_byte), .o_Valid(o_valid),
        .o_Error(o_error), .o_Busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_error();
        exp_t e;
        e.err = 1'b1; e.b = m_last; e.d = m_hist;
        sb.push_back(e);
    endtask

    // Frame-level model: a frame is accepted when its stop bit is 1 and, with
    // parity checking enabled, the 9 data+parity bits hold an odd number of ones.
    task automatic model_frame(input logic [7:0] b, input logic p, input logic stop);
        exp_t e;
        logic ok;
`ifdef PS2_PARITY_CHECK_EN
        ok = stop && ($countones({b, p}) % 2 == 1);
`else
        ok = stop;
`endif
        if (ok) begin
            m_hist = {m_hist[15:0], b};
            m_last = b;
            e.err = 1'b0; e.b = m_last; e.d = m_hist;
            sb.push_back(e);
        end else begin
            expect_error();
        end
    endtask

    task automatic send_bit(input logic v);
        ps2d = v;
        repeat (HALF) @(posedge clk);
        ps2c = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2c = 1'b1;
    endtask

    // flip=1 sends the wrong parity bit; stop=0 sends a bad stop bit.
    task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop);
        logic p;
        p = ~(^b) ^ flip;
        model_frame(b, p, stop);
        send_bit(1'b0);
        check("busy_in_frame", 32'(o_busy), 32'd1);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(stop);
        check("busy_after_frame", 32'(o_busy), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && (o_valid || o_error)) begin
            exp_t e;
            check("valid_error_exclusive", 32'(o_valid && o_error), 32'd0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output valid=%0b error=%0b byte=0x%0h expected=none", o_valid, o_error, o_byte);
            end else begin
                e = sb.pop_front();
                check("sb_is_error", 32'(o_error), 32'(e.err));
                check("sb_byte", 32'(o_byte), 32'(e.b));
                check("sb_data", 32'(o_data), 32'(e.d));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", 32'(o_data), 32'd0);
        check("reset_byte", 32'(o_byte), 32'd0);
        check("reset_flags", {29'd0, o_valid, o_error, o_busy}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        send_frame(8'h1C, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        check("history_pair", 32'(o_data), 32'h001CF01C);

        // Reset four bits into a frame clears everything including the history.
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_data", 32'(o_data), 32'd0);
        check("midreset_byte", 32'(o_byte), 32'd0);
        check("midreset_flags", {29'd0, o_valid, o_error, o_busy}, 32'd0);
        m_hist = '0;
        m_last = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        send_frame(8'hF0, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        check("after_reset_data", 32'(o_data), 32'h000000F0);

        send_frame(8'h1C, 1'b1, 1'b1);
        repeat (10) @(posedge clk);

        // Short low glitch on the clock line must be filtered out.
        ps2c = 1'b0;
        repeat (FL - 3) @(posedge clk);
        ps2c = 1'b1;
        repeat (HALF) @(posedge clk);
        send_frame(8'h32, 1'b0, 1'b1);
        repeat (10) @(posedge clk);

        expect_error();
        send_bit(1'b1);
        check("bad_start_idle", 32'(o_busy), 32'd0);

        expect_error();
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        check("partial_busy", 32'(o_busy), 32'd1);
        repeat (TO + 100) @(posedge clk);
        check("timeout_busy", 32'(o_busy), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1);
        repeat (10) @(posedge clk);

        for (int n = 0; n < 20; n++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            send_frame(b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0));
            repeat ($urandom_range(0, 30)) @(posedge clk);
        end

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
